// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - raster timing bundle from vga_sync_gen to its consumers
//
// Purpose: carries the pixel-tick enable, the undelayed raster counters and
//          decodes, and the latency-matched sync/active outputs.
// Signals:
//   pix_en       pixel-tick enable (every second CLK_50 cycle)
//   pixel_x/y    current raster position (undelayed)
//   active       visible-area flag (undelayed)
//   active_d     active delayed by the pipeline
//   h_sync/v_sync  delayed syncs at the configured polarity
//   line_start   pulse on the pix_en cycle of pixel_x==0
//   frame_start  pulse on the pix_en cycle of (0,0)
// Modports: master = timing generator, slave = consumer.
interface vga_sync_gen_if;
    logic       pix_en;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       active;
    logic       active_d;
    logic       h_sync;
    logic       v_sync;
    logic       line_start;
    logic       frame_start;

    modport master (
        output pix_en, pixel_x, pixel_y, active, active_d,
               h_sync, v_sync, line_start, frame_start
    );

    modport slave (
        input pix_en, pixel_x, pixel_y, active, active_d,
              h_sync, v_sync, line_start, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - 640x480@60 VGA raster timing generator with latency-matched syncs
//
// Purpose: derives a 25 MHz pixel tick from CLK_50, runs the horizontal and
//          vertical raster counters, and delays the sync/active decode by
//          PIPE_DELAY pixel ticks so it lines up with downstream pixel latency.
// Ports:
//   CLK_50   system clock, the only clock
//   resetN   synchronous active-low reset
//   vga      vga_sync_gen_if.master timing outputs
module vga_sync_gen #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int PIPE_DELAY  = 2,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic           CLK_50,
    input  logic           resetN,
    vga_sync_gen_if.master vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    if (H_TOTAL > 1024) begin : g_err_h_total
        $error("vga_sync_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_err_v_total
        $error("vga_sync_gen: V_TOTAL exceeds 1024");
    end
    if (PIPE_DELAY > 7 || PIPE_DELAY < 0) begin : g_err_pipe
        $error("vga_sync_gen: PIPE_DELAY must be 0..7");
    end

    logic       phase;
    logic       pix_en;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;

    // pix_en lags the phase flop by one cycle so the first cycle after reset
    // release is a non-tick cycle, and the tick itself comes from a flop.
    always_ff @(posedge CLK_50) begin
        if (!resetN) begin
            phase   <= 1'b0;
            pix_en  <= 1'b0;
            pixel_x <= '0;
            pixel_y <= '0;
        end else begin
            phase  <= ~phase;
            pix_en <= phase;
            if (pix_en) begin
                if (pixel_x == H_LAST) begin
                    pixel_x <= '0;
                    if (pixel_y == V_LAST) begin
                        pixel_y <= '0;
                    end else begin
                        pixel_y <= pixel_y + 10'd1;
                    end
                end else begin
                    pixel_x <= pixel_x + 10'd1;
                end
            end
        end
    end

    logic active_raw;
    logic hs_raw;
    logic vs_raw;

    assign active_raw = (pixel_x < H_VIS) && (pixel_y < V_VIS);
    assign hs_raw     = (pixel_x >= HS_FIRST) && (pixel_x <= HS_LAST);
    assign vs_raw     = (pixel_y >= VS_FIRST) && (pixel_y <= VS_LAST);

    logic hs_d;
    logic vs_d;
    logic act_d;

    // Pipeline stages hold the asserted-true form of each flag; polarity is
    // applied only at the output so a flushed stage reads as "not asserted".
    if (PIPE_DELAY == 0) begin : g_no_delay
        assign hs_d  = hs_raw;
        assign vs_d  = vs_raw;
        assign act_d = active_raw;
    end else begin : g_delay
        logic [2:0] stage [PIPE_DELAY];

        always_ff @(posedge CLK_50) begin
            if (!resetN) begin
                for (int i = 0; i < PIPE_DELAY; i++) begin
                    stage[i] <= 3'b000;
                end
            end else if (pix_en) begin
                stage[0] <= {hs_raw, vs_raw, active_raw};
                for (int i = 1; i < PIPE_DELAY; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign {hs_d, vs_d, act_d} = stage[PIPE_DELAY-1];
    end

    assign vga.pix_en      = pix_en;
    assign vga.pixel_x     = pixel_x;
    assign vga.pixel_y     = pixel_y;
    assign vga.active      = active_raw;
    assign vga.active_d    = act_d;
    assign vga.h_sync      = hs_d ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign vga.v_sync      = vs_d ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign vga.line_start  = pix_en && (pixel_x == 10'd0);
    assign vga.frame_start = pix_en && (pixel_x == 10'd0) && (pixel_y == 10'd0);

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - directed self-checking bench for vga_sync_gen
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic resetN = 1'b0;

    always #5 clk = ~clk;

    vga_sync_gen_if m ();
    vga_sync_gen_if z ();
    vga_sync_gen_if f ();
    vga_sync_gen_if s ();

    vga_sync_gen #(.PIPE_DELAY(2)) u_m (.CLK_50(clk), .resetN(resetN), .vga(m));
    vga_sync_gen #(.PIPE_DELAY(0)) u_z (.CLK_50(clk), .resetN(resetN), .vga(z));
    vga_sync_gen #(.PIPE_DELAY(5)) u_f (.CLK_50(clk), .resetN(resetN), .vga(f));
    vga_sync_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .PIPE_DELAY(1)
    ) u_s (.CLK_50(clk), .resetN(resetN), .vga(s));

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // y < 0 matches any line
    task automatic wait_m(input int x, input int y, input logic en, input string tag);
        int n = 0;
        while (!(m.pixel_x == 10'(x) && (y < 0 || m.pixel_y == 10'(y)) && m.pix_en == en)
               && n < 40000) begin
            step();
            n++;
        end
        check(tag, 32'(n < 40000), 32'd1);
    endtask

    task automatic wait_s(input int x, input int y, input logic en, input string tag);
        int n = 0;
        while (!(s.pixel_x == 10'(x) && s.pixel_y == 10'(y) && s.pix_en == en) && n < 2000) begin
            step();
            n++;
        end
        check(tag, 32'(n < 2000), 32'd1);
    endtask

    // One reset edge, then release and walk the start-up sequence.
    task automatic reset_and_release(input string p);
        resetN = 1'b0;
        step();
        check({p, "rst_pix_en"},      32'(m.pix_en), 32'd0);
        check({p, "rst_x"},           32'(m.pixel_x), 32'd0);
        check({p, "rst_y"},           32'(m.pixel_y), 32'd0);
        check({p, "rst_active"},      32'(m.active), 32'd1);
        check({p, "rst_active_d"},    32'(m.active_d), 32'd0);
        check({p, "rst_h_sync"},      32'(m.h_sync), 32'd1);
        check({p, "rst_v_sync"},      32'(m.v_sync), 32'd1);
        check({p, "rst_line_start"},  32'(m.line_start), 32'd0);
        check({p, "rst_frame_start"}, 32'(m.frame_start), 32'd0);
        check({p, "rst_f_active_d"},  32'(f.active_d), 32'd0);
        check({p, "rst_f_h_sync"},    32'(f.h_sync), 32'd1);
        check({p, "rst_z_active_d"},  32'(z.active_d), 32'd1);
        resetN = 1'b1;
        step();
        check({p, "r1_pix_en"},       32'(m.pix_en), 32'd0);
        check({p, "r1_line_start"},   32'(m.line_start), 32'd0);
        check({p, "r1_x"},            32'(m.pixel_x), 32'd0);
        step();
        check({p, "r2_pix_en"},       32'(m.pix_en), 32'd1);
        check({p, "r2_line_start"},   32'(m.line_start), 32'd1);
        check({p, "r2_frame_start"},  32'(m.frame_start), 32'd1);
        step();
        check({p, "r3_pix_en"},       32'(m.pix_en), 32'd0);
        check({p, "r3_x"},            32'(m.pixel_x), 32'd1);
        check({p, "r3_line_start"},   32'(m.line_start), 32'd0);
        check({p, "r3_frame_start"},  32'(m.frame_start), 32'd0);
        check({p, "r3_active_d"},     32'(m.active_d), 32'd0);
        step();
        check({p, "r4_active_d"},     32'(m.active_d), 32'd0);
        step();
        check({p, "r5_active_d"},     32'(m.active_d), 32'd1);
        check({p, "r5_x"},            32'(m.pixel_x), 32'd2);
        repeat (5) step();
        check({p, "r10_f_active_d"},  32'(f.active_d), 32'd0);
        step();
        check({p, "r11_f_active_d"},  32'(f.active_d), 32'd1);
    endtask

    initial begin
        int n;
        resetN = 1'b0;
        repeat (3) step();
        reset_and_release("a_");

        // Horizontal sync on line 0, delay 2 ticks.
        wait_m(656, 0, 1'b0, "hs_wait");
        check("hs_z_lag0", 32'(z.h_sync), 32'd0);
        check("hs_m_t0", 32'(m.h_sync), 32'd1);
        repeat (3) step();
        check("hs_m_t3", 32'(m.h_sync), 32'd1);
        step();
        check("hs_m_t4", 32'(m.h_sync), 32'd0);
        check("hs_m_t4_x", 32'(m.pixel_x), 32'd658);
        n = 0;
        while (m.h_sync == 1'b0 && n < 1000) begin
            step();
            n++;
        end
        check("hs_low_cycles", 32'(n), 32'd192);
        check("hs_end_x", 32'(m.pixel_x), 32'd754);

        // active rising at start of line 1, lag 0 and 10 cycles.
        wait_m(799, 0, 1'b1, "act_wait");
        check("act_before", 32'(m.active), 32'd0);
        check("act_z_before", 32'(z.active_d), 32'd0);
        step();
        check("act_rise", 32'(m.active), 32'd1);
        check("act_z_lag0", 32'(z.active_d), 32'd1);
        repeat (9) step();
        check("act_f_t9", 32'(f.active_d), 32'd0);
        step();
        check("act_f_t10", 32'(f.active_d), 32'd1);

        // h_sync with delay 5 on line 1.
        wait_m(656, 1, 1'b0, "hs5_wait");
        check("hs5_z_lag0", 32'(z.h_sync), 32'd0);
        repeat (9) step();
        check("hs5_t9", 32'(f.h_sync), 32'd1);
        step();
        check("hs5_t10", 32'(f.h_sync), 32'd0);

        // Line wrap (799,10) -> (0,11).
        wait_m(799, 10, 1'b1, "wrap_wait");
        check("wrap_pre_active", 32'(m.active), 32'd0);
        step();
        check("wrap_x", 32'(m.pixel_x), 32'd0);
        check("wrap_y", 32'(m.pixel_y), 32'd11);
        check("wrap_active", 32'(m.active), 32'd1);
        step();
        check("wrap_line_start", 32'(m.line_start), 32'd1);
        check("wrap_frame_start", 32'(m.frame_start), 32'd0);

        // Frame wrap on the reduced raster (16 x 8).
        wait_s(15, 7, 1'b1, "s_wrap_wait");
        step();
        check("s_wrap_x", 32'(s.pixel_x), 32'd0);
        check("s_wrap_y", 32'(s.pixel_y), 32'd0);
        step();
        check("s_wrap_frame_start", 32'(s.frame_start), 32'd1);
        n = 1;
        step();
        while (s.frame_start !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        check("s_frame_period", 32'(n), 32'd256);
        n = 0;
        while (s.v_sync !== 1'b0 && n < 1000) begin
            step();
            n++;
        end
        check("s_vs_wait", 32'(n < 1000), 32'd1);
        n = 0;
        while (s.v_sync == 1'b0 && n < 1000) begin
            step();
            n++;
        end
        check("s_vs_low_cycles", 32'(n), 32'd64);

        // Mid-line reset with h_sync asserted in the pipeline.
        wait_m(700, -1, 1'b0, "mid_wait");
        check("mid_h_sync_asserted", 32'(m.h_sync), 32'd0);
        reset_and_release("b_");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
